// File: rtl/decodificador_comando.sv
// Two-byte request frame decoder (command + sensor address) fed by the UART receiver strobe.
// Validates the frame, enforces an inter-byte timeout and hands accepted requests downstream.
module decodificador_comando #(
    parameter int         TIMEOUT_CICLOS = 5000000,
    parameter logic [7:0] CODIGO_MAX     = 8'h07,
    parameter int         NUM_SENSORES   = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bitsEstaoRecebidos,
    input  logic [7:0] byteCompleto,
    input  logic       requisicaoAceita,
    output logic       requisicaoValida,
    output logic [7:0] comando,
    output logic [7:0] endereco,
    output logic       erroComando,
    output logic       erroEndereco,
    output logic       erroTempo,
    output logic       erroSobreposicao,
    output logic       ocupado
);

    localparam int                       LARGURA_TIMER   = $clog2(TIMEOUT_CICLOS) + 1;
    localparam logic [LARGURA_TIMER-1:0] TIMER_FINAL     = LARGURA_TIMER'(TIMEOUT_CICLOS - 1);
    localparam logic [8:0]               LIMITE_ENDERECO = 9'(NUM_SENSORES);

    typedef enum logic [1:0] {
        ESPERA_COMANDO  = 2'd0,
        ESPERA_ENDERECO = 2'd1,
        VALIDA          = 2'd2,
        ENTREGA         = 2'd3
    } estado_t;

    estado_t                  estado;
    logic [LARGURA_TIMER-1:0] timer;

    // Frame FSM with registered request, field and single-cycle error outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado           <= ESPERA_COMANDO;
            timer            <= '0;
            comando          <= 8'h00;
            endereco         <= 8'h00;
            requisicaoValida <= 1'b0;
            erroComando      <= 1'b0;
            erroEndereco     <= 1'b0;
            erroTempo        <= 1'b0;
            erroSobreposicao <= 1'b0;
            ocupado          <= 1'b0;
        end else begin
            erroComando      <= 1'b0;
            erroEndereco     <= 1'b0;
            erroTempo        <= 1'b0;
            erroSobreposicao <= 1'b0;

            case (estado)
                ESPERA_COMANDO: begin
                    if (bitsEstaoRecebidos) begin
                        comando <= byteCompleto;
                        timer   <= '0;
                        estado  <= ESPERA_ENDERECO;
                    end else begin
                        estado  <= ESPERA_COMANDO;
                    end
                end

                ESPERA_ENDERECO: begin
                    // A strobe arriving on the final timer value still completes the frame.
                    if (bitsEstaoRecebidos) begin
                        endereco <= byteCompleto;
                        ocupado  <= 1'b1;
                        estado   <= VALIDA;
                    end else if (timer == TIMER_FINAL) begin
                        erroTempo <= 1'b1;
                        estado    <= ESPERA_COMANDO;
                    end else begin
                        timer     <= timer + LARGURA_TIMER'(1);
                    end
                end

                VALIDA: begin
                    // Validation errors take precedence so only one error line pulses;
                    // a colliding byte is then dropped silently.
                    if (comando > CODIGO_MAX) begin
                        erroComando <= 1'b1;
                        ocupado     <= 1'b0;
                        estado      <= ESPERA_COMANDO;
                    end else if ({1'b0, endereco} >= LIMITE_ENDERECO) begin
                        erroEndereco <= 1'b1;
                        ocupado      <= 1'b0;
                        estado       <= ESPERA_COMANDO;
                    end else begin
                        requisicaoValida <= 1'b1;
                        erroSobreposicao <= bitsEstaoRecebidos;
                        estado           <= ENTREGA;
                    end
                end

                ENTREGA: begin
                    erroSobreposicao <= bitsEstaoRecebidos;
                    if (requisicaoAceita) begin
                        requisicaoValida <= 1'b0;
                        ocupado          <= 1'b0;
                        estado           <= ESPERA_COMANDO;
                    end else begin
                        estado           <= ENTREGA;
                    end
                end

                default: begin
                    requisicaoValida <= 1'b0;
                    ocupado          <= 1'b0;
                    estado           <= ESPERA_COMANDO;
                end
            endcase
        end
    end

endmodule

// File: doc/decodificador_comando.md
# decodificador_comando

Frame decoder directly downstream of the UART receiver. It consumes the receiver's one-cycle byte strobe and 8-bit data, and assembles two-byte request frames: a command byte followed by a sensor-address byte. It validates the frame, enforces an inter-byte timeout, and presents each accepted request to the sensor-control logic through a valid/accept handshake.

## Interface
- `TIMEOUT_CICLOS`, default 5000000: maximum cycles allowed between the command strobe and the address strobe (100 ms at 50 MHz).
- `CODIGO_MAX`, default 8'h07: highest legal command code; legal codes are 0..`CODIGO_MAX`.
- `NUM_SENSORES`, default 32: legal addresses are 0..`NUM_SENSORES`-1.

Ports:
- `clock` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high.
- `bitsEstaoRecebidos` in 1: one-cycle byte-valid strobe from the UART receiver.
- `byteCompleto` in 8: received byte, valid when the strobe is high.
- `requisicaoAceita` in 1: downstream accepts the pending request.
- `requisicaoValida` out 1: level; a request is pending.
- `comando` out 8: command of the pending request.
- `endereco` out 8: address of the pending request.
- `erroComando` out 1: one-cycle pulse; illegal command code.
- `erroEndereco` out 1: one-cycle pulse; address out of range.
- `erroTempo` out 1: one-cycle pulse; inter-byte timeout.
- `erroSobreposicao` out 1: one-cycle pulse; byte arrived while busy and was dropped.
- `ocupado` out 1: high in VALIDA and ENTREGA.

## Operation
- Reset drives every output to 0 and the state to ESPERA_COMANDO. `comando`, `endereco` and the timer are cleared. Reset has priority over all other inputs in every state.
- ESPERA_COMANDO:
  - On a strobe, latch `byteCompleto` into `comando`, clear the timer, and go to ESPERA_ENDERECO.
  - Without a strobe, stay.
- ESPERA_ENDERECO:
  - On a strobe, latch the byte into `endereco` and go to VALIDA.
  - Otherwise increment the timer. When the timer is at `TIMEOUT_CICLOS`-1 and no strobe is present, pulse `erroTempo` and return to ESPERA_COMANDO.
  - A strobe in the same cycle as the final timer value wins; there is no error in that case.
  - Timer width is $clog2(`TIMEOUT_CICLOS`)+1 bits, and it never wraps.
- VALIDA (exactly one cycle):
  - If `comando` > `CODIGO_MAX`, pulse `erroComando` and go to ESPERA_COMANDO.
  - Else if `endereco` >= `NUM_SENSORES`, pulse `erroEndereco` and go to ESPERA_COMANDO.
  - Else set `requisicaoValida` and go to ENTREGA.
  - When both fields are illegal, only `erroComando` pulses.
- ENTREGA:
  - `requisicaoValida`, `comando` and `endereco` stay constant.
  - When `requisicaoAceita` is sampled high, clear `requisicaoValida` and go to ESPERA_COMANDO.
- `requisicaoAceita` is ignored in all states except ENTREGA.
- A strobe in VALIDA or ENTREGA drops the byte and pulses `erroSobreposicao`; state and outputs are otherwise unaffected.
- Error outputs are registered; at most one of them is high in any cycle.

## Timing
- Address strobe sampled at edge N: state is VALIDA after N. `requisicaoValida` or the error pulse is high after edge N+1.
- Latency from the second strobe to request visible: 2 cycles.
- Accept sampled at edge M: `requisicaoValida` is low after M, and the state is ESPERA_COMANDO after M.
  - A strobe sampled at M+1 starts a new frame.
  - A strobe sampled at edge M itself is a sobreposicao and is dropped.
- `requisicaoAceita` may already be high in the first cycle `requisicaoValida` is high. The request is then accepted at that edge, and `requisicaoValida` is high for exactly one cycle.
- Back-to-back strobes on consecutive cycles (command then address) are legal.
- Reset asserted during ENTREGA: `requisicaoValida` is low after that edge, and no acceptance occurs.
- Reset in ESPERA_ENDERECO discards the partial frame and raises no error.
- Minimum frame period with immediate accept: 4 cycles. The real rate is bounded by the UART (about 10 bit-times per byte).

## Test plan
- Valid frame: strobe 0x03, then 0x05 ten cycles later, accept held high. Expect `requisicaoValida` high for 1 cycle, 2 cycles after the second strobe, with `comando`=0x03 and `endereco`=0x05.
- Illegal codes: frame 0x08,0x01 gives `erroComando` only. Frame 0x02,0x20 gives `erroEndereco` only. Frame 0x09,0x40 gives `erroComando` only. `requisicaoValida` never rises in any of these.
- Timeout, with `TIMEOUT_CICLOS`=16:
  - Command strobe then no strobe: `erroTempo` pulses exactly once, 16 cycles after the command edge, then the state is idle.
  - Address strobe at cycle 16: accepted, no error.
  - Address strobe at cycle 17: treated as a new command byte.
- Handshake hold: valid frame with `requisicaoAceita` low for 50 cycles. `requisicaoValida`, `comando` and `endereco` stay stable. Extra strobes each give one `erroSobreposicao` pulse. Raising accept drops valid on the next edge.
- Reset mid-operation:
  - Reset in ENTREGA gives all outputs 0 on the next cycle.
  - Reset after the command byte discards the partial frame; a following full frame 0x01,0x00 decodes correctly.
- Back-to-back: 100 random legal frames at maximum rate with accept tied high. Every frame is reported in order with matching fields and no error pulses.
